// File: rtl/uart_rx_oversampled.sv
// 8-bit oversampling UART receiver with a fractional-accumulator tick.
// Optional parity stage is enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD          = 115200,
  parameter int OVERSAMPLING  = 8,
  parameter int PARITY_ODD    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam int ACC_W =
    $clog2(CLK_FREQUENCY / (BAUD * OVERSAMPLING)) + 8;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 1;
  localparam longint unsigned RATE =
    longint'(BAUD) * longint'(OVERSAMPLING);
  localparam longint unsigned INC_RAW =
    ((RATE << (ACC_W + 1)) / longint'(CLK_FREQUENCY) + 1) >> 1;
  localparam longint unsigned INC_LIM =
    (INC_RAW > ACC_MAX) ? ACC_MAX : INC_RAW;
  localparam logic [ACC_W-1:0] INC = INC_LIM[ACC_W-1:0];
  localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLING / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLING - 1);

  if (OVERSAMPLING < 4 ||
      (OVERSAMPLING & (OVERSAMPLING - 1)) != 0) begin : g_assertion_error
    $error("ASSERTION_ERROR: OVERSAMPLING must be a power of two >= 4");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_parity_odd_check
    $error("ASSERTION_ERROR: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_t;
`endif

  state_t state;
  state_t state_n;

  logic [1:0]       sync;
  logic             rxd_s;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             cnt_clr;
  logic             shift_en;
  logic             done;
  logic             par_err_c;

  assign rxd_s   = sync[1];
  assign acc_sum = {1'b0, acc} + {1'b0, INC};
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[0], rxd};
      acc  <= acc_sum[ACC_W-1:0];
      tick <= acc_sum[ACC_W];
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en;
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst) par_bit <= 1'b0;
    else if (par_en) par_bit <= rxd_s;
  end

  assign par_err_c = ^shift ^ par_bit ^ PARITY_ODD[0];
`else
  assign par_err_c = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
`endif
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_n = START;
            cnt_clr = 1'b1;
          end
        end
        START: begin
          // Line back high at mid start bit: treat as a glitch
          if (cnt == HALF) begin
            cnt_clr = 1'b1;
            state_n = rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (idx == 3'd7) state_n = PARITY;
`else
            if (idx == 3'd7) state_n = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            par_en  = 1'b1;
            state_n = STOP;
          end
        end
`endif
        STOP: begin
          // Leave at the stop-bit centre so a following start edge is seen
          if (cnt == LAST) begin
            done    = 1'b1;
            state_n = rxd_s ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (rxd_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= 3'd0;
      shift      <= 8'h00;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      data_valid <= done;
      if (tick) cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state != DATA) idx <= 3'd0;
      else if (shift_en) idx <= idx + 3'd1;
      if (shift_en) shift <= {rxd_s, shift[7:1]};
      if (done) begin
        data       <= shift;
        frame_err  <= ~rxd_s;
        parity_err <= par_err_c;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed and randomized frames checked against a queue-based model
// of the expected byte stream for uart_rx_oversampled.
module tb_uart_rx_oversampled;

  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 115200;
  localparam int OS     = 8;
  localparam int BIT    = 434;
  localparam int FAST   = 426;
  localparam int SLOW   = 443;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR_ODD = 1'b0;
`else
  localparam int NB = 10;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int   obs_cyc[$];

  uart_rx_oversampled #(
    .CLK_FREQUENCY(CLK_HZ),
    .BAUD(BAUD),
    .OVERSAMPLING(OS),
    .PARITY_ODD(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .data(data),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      obs_q.push_back({data, frame_err, parity_err});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_raw(input logic [11:0] bits,
                          input int n,
                          input int bclk);
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      wait_clk(bclk);
    end
  endtask

  function automatic logic [11:0] frame(input logic [7:0] b,
                                        input logic stop);
`ifdef UART_RX_PARITY_EN
    return {1'b0, stop, ^b ^ PAR_ODD, b, 1'b0};
`else
    return {2'b00, stop, b, 1'b0};
`endif
  endfunction

  task automatic expect_byte(input logic [7:0] b,
                             input logic fe,
                             input logic pe);
    exp_q.push_back({b, fe, pe});
  endtask

  task automatic settle_and_compare(input string tag);
    wait_clk(BIT);
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s[%0d].data", tag, i), obs_q[i].d, exp_q[i].d);
      check($sformatf("%s[%0d].fe", tag, i), obs_q[i].fe, exp_q[i].fe);
      check($sformatf("%s[%0d].pe", tag, i), obs_q[i].pe, exp_q[i].pe);
    end
    obs_q.delete();
    exp_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] seq [3];
    int edge_cyc;
    int lat;
    int bclk;
    int gap;

    rst = 1'b1;
    rxd = 1'b1;
    wait_clk(3);
    check("rst.data", data, 8'h00);
    check("rst.valid", data_valid, 1'b0);
    check("rst.fe", frame_err, 1'b0);
    check("rst.pe", parity_err, 1'b0);
    check("rst.busy", busy, 1'b0);
    rst = 1'b0;
    wait_clk(100);

    edge_cyc = cyc;
    send_raw(frame(8'h55, 1'b1), NB, BIT);
    expect_byte(8'h55, 1'b0, 1'b0);
    lat = (obs_cyc.size() > 0) ? obs_cyc[0] - edge_cyc : -1;
`ifdef UART_RX_PARITY_EN
    check("t1.latency_ok", (lat >= 4540 && lat <= 4640), 1'b1);
`else
    check("t1.latency_ok", (lat >= 4110 && lat <= 4200), 1'b1);
`endif
    settle_and_compare("t1");
    check("t1.hold", data, 8'h55);

    rxd = 1'b0;
    wait_clk(100);
    check("t2.busy_hi", busy, 1'b1);
    wait_clk(9);
    rxd = 1'b1;
    wait_clk(4 * BIT);
    check("t2.busy_lo", busy, 1'b0);
    settle_and_compare("t2");

    send_raw(frame(8'hA3, 1'b0), NB, BIT);
    expect_byte(8'hA3, 1'b1, 1'b0);
    wait_clk(3 * BIT);
    check("t3.busy_break", busy, 1'b1);
    check("t3.single", obs_q.size(), 1);
    rxd = 1'b1;
    wait_clk(2 * BIT);
    b = 8'($urandom_range(0, 255));
    send_raw(frame(b, 1'b1), NB, BIT);
    expect_byte(b, 1'b0, 1'b0);
    settle_and_compare("t3");

    seq[0] = 8'hA5;
    seq[1] = 8'h3C;
    seq[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      send_raw(frame(seq[i], 1'b1), NB, FAST);
      expect_byte(seq[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      send_raw(frame(seq[i], 1'b1), NB, SLOW);
      expect_byte(seq[i], 1'b0, 1'b0);
    end
    settle_and_compare("t4");
    check("t4.hold", data, 8'hFF);

    fork
      send_raw(frame(8'h0F, 1'b1), NB, BIT);
      begin
        wait_clk(5 * BIT + BIT / 2);
        rst = 1'b1;
        wait_clk(1);
        check("t5.rst_data", data, 8'h00);
        check("t5.rst_valid", data_valid, 1'b0);
        check("t5.rst_fe", frame_err, 1'b0);
        check("t5.rst_busy", busy, 1'b0);
        wait_clk(NB * BIT - (5 * BIT + BIT / 2) + 10);
        rst = 1'b0;
      end
    join
    wait_clk(BIT);
    send_raw(frame(8'h81, 1'b1), NB, BIT);
    expect_byte(8'h81, 1'b0, 1'b0);
    settle_and_compare("t5");

    for (int i = 0; i < 3; i++) begin
      b    = 8'($urandom_range(0, 255));
      bclk = BIT - 8 + int'($urandom_range(0, 16));
      gap  = int'($urandom_range(0, 200));
      send_raw(frame(b, 1'b1), NB, bclk);
      expect_byte(b, 1'b0, 1'b0);
      wait_clk(gap);
    end
    settle_and_compare("rnd");

`ifdef UART_RX_PARITY_EN
    send_raw({1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, NB, BIT);
    expect_byte(8'h01, 1'b0, 1'b1);
    send_raw({1'b0, 1'b1, 1'b1, 8'h01, 1'b0}, NB, BIT);
    expect_byte(8'h01, 1'b0, 1'b0);
    settle_and_compare("t6");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
